// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Sequencing FSM for the multicycle ARM datapath. Decodes Instr[31:12], walks
// the datapath through fetch/decode/execute/memory/writeback, holds the NZCV
// flags and evaluates the condition field once per instruction (in DECODE).
// Optional feature (macro MCU_ILLEGAL_TRAP_EN): op=11 and undefined
// data-processing commands trap into HALT, flagged on the Illegal output.
module multicycle_control_unit #(
  parameter logic [3:0]  RESET_FLAGS = 4'b0000,
  parameter int unsigned STATE_W     = 4
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [19:0]        Instr,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [3:0]         Flags,
`ifdef MCU_ILLEGAL_TRAP_EN
  output logic               Illegal,
`endif
  output logic [STATE_W-1:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  // Instruction fields (Instr holds IR bits 31:12)
  logic [3:0] cond_s;
  logic [1:0] op_s;
  logic [5:0] funct_s;
  logic [3:0] rd_s;
  logic [3:0] cmd_s;
  logic       unused_s;

  assign cond_s   = Instr[19:16];
  assign op_s     = Instr[15:14];
  assign funct_s  = Instr[13:8];
  assign rd_s     = Instr[3:0];
  assign cmd_s    = funct_s[4:1];
  assign unused_s = ^Instr[7:4];  // Rn is consumed by the datapath only

  // ARM condition-code evaluation against {N,Z,C,V}
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // ALU decoder: unknown commands fall back to ADD
  function automatic logic [1:0] alu_dec(input logic [3:0] cmd);
    logic [1:0] r;
    case (cmd)
      4'b0100: r = 2'b00;
      4'b0010: r = 2'b01;
      4'b0000: r = 2'b10;
      4'b1100: r = 2'b11;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  logic       cmd_defined_s;
  logic [1:0] flag_w_s;
  logic       exec_s;

  assign cmd_defined_s = (cmd_s == 4'b0100) | (cmd_s == 4'b0010) |
                         (cmd_s == 4'b0000) | (cmd_s == 4'b1100);
  assign flag_w_s[1]   = funct_s[0];
  assign flag_w_s[0]   = funct_s[0] & ((cmd_s == 4'b0100) | (cmd_s == 4'b0010));

  state_t     state_r, next_s;
  logic       cond_ok_r;
  logic [3:0] flags_r;

  assign exec_s = (state_r == S_EXECR) | (state_r == S_EXECI);

  // State register; reset aborts any instruction in flight
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Condition result captured at the end of DECODE, held for the instruction
  always_ff @(posedge CLK) begin
    if (reset) begin
      cond_ok_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      cond_ok_r <= cond_eval(cond_s, flags_r);
    end else begin
      cond_ok_r <= cond_ok_r;
    end
  end

  // NZCV register, updated at the end of EXECR/EXECI for passing S-instructions
  always_ff @(posedge CLK) begin
    if (reset) begin
      flags_r <= RESET_FLAGS;
    end else if (exec_s && cond_ok_r) begin
      if (flag_w_s[1]) begin
        flags_r[3:2] <= ALUFlags[3:2];
      end
      if (flag_w_s[0]) begin
        flags_r[1:0] <= ALUFlags[1:0];
      end
    end else begin
      flags_r <= flags_r;
    end
  end

  // Next-state logic
  always_comb begin
    next_s = S_FETCH;
    case (state_r)
      S_FETCH:  next_s = S_DECODE;
      S_DECODE: begin
        case (op_s)
          2'b00: begin
`ifdef MCU_ILLEGAL_TRAP_EN
            if (!cmd_defined_s) begin
              next_s = S_HALT;
            end else
`endif
            if (funct_s[5]) begin
              next_s = S_EXECI;
            end else begin
              next_s = S_EXECR;
            end
          end
          2'b01: next_s = S_MEMADR;
          2'b10: next_s = S_BRANCH;
`ifdef MCU_ILLEGAL_TRAP_EN
          2'b11: next_s = S_HALT;
`else
          2'b11: next_s = S_FETCH;
`endif
          default: next_s = S_FETCH;
        endcase
      end
      S_MEMADR: next_s = funct_s[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_s = S_MEMWB;
      S_MEMWB:  next_s = S_FETCH;
      S_MEMWR:  next_s = S_FETCH;
      S_EXECR:  next_s = S_ALUWB;
      S_EXECI:  next_s = S_ALUWB;
      S_ALUWB:  next_s = S_FETCH;
      S_BRANCH: next_s = S_FETCH;
`ifdef MCU_ILLEGAL_TRAP_EN
      S_HALT:   next_s = S_HALT;
`endif
      default:  next_s = S_FETCH;
    endcase
  end

  logic       pc_write_s, adr_src_s, mem_write_s, ir_write_s, reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] result_src_s, alu_src_b_s, alu_control_s;
  logic       rd_pc_s;

  assign rd_pc_s = (rd_s == 4'hF);

  // Per-state datapath controls; HALT and unused encodings drive everything 0
  always_comb begin
    pc_write_s    = 1'b0;
    adr_src_s     = 1'b0;
    mem_write_s   = 1'b0;
    ir_write_s    = 1'b0;
    reg_write_s   = 1'b0;
    result_src_s  = 2'b00;
    alu_src_a_s   = 1'b0;
    alu_src_b_s   = 2'b00;
    alu_control_s = 2'b00;
    case (state_r)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        pc_write_s   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
      end
      S_MEMADR: alu_src_b_s = 2'b01;
      S_MEMRD:  adr_src_s = 1'b1;
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = cond_ok_r;
        pc_write_s   = cond_ok_r & rd_pc_s;
      end
      S_MEMWR: begin
        adr_src_s   = 1'b1;
        mem_write_s = cond_ok_r;
      end
      S_EXECR:  alu_control_s = alu_dec(cmd_s);
      S_EXECI: begin
        alu_src_b_s   = 2'b01;
        alu_control_s = alu_dec(cmd_s);
      end
      S_ALUWB: begin
        reg_write_s = cond_ok_r;
        pc_write_s  = cond_ok_r & rd_pc_s;
      end
      S_BRANCH: begin
        alu_src_b_s  = 2'b01;
        result_src_s = 2'b10;
        pc_write_s   = cond_ok_r;
      end
      default: begin
        pc_write_s = 1'b0;
      end
    endcase
  end

  // Architectural enables are held off while reset is asserted
  assign PCWrite    = pc_write_s  & ~reset;
  assign IRWrite    = ir_write_s  & ~reset;
  assign RegWrite   = reg_write_s & ~reset;
  assign MemWrite   = mem_write_s & ~reset;
  assign AdrSrc     = adr_src_s;
  assign ResultSrc  = result_src_s;
  assign ALUSrcA    = alu_src_a_s;
  assign ALUSrcB    = alu_src_b_s;
  assign ALUControl = alu_control_s;
  assign ImmSrc     = op_s;
  assign RegSrc     = {op_s == 2'b01, op_s == 2'b10};
  assign Flags      = flags_r;
  assign State      = STATE_W'(state_r);
`ifdef MCU_ILLEGAL_TRAP_EN
  assign Illegal    = (state_r == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: directed vector table, hand-written
// reset/trap sequences, and randomized instructions against an
// instruction-level reference model.
module tb_multicycle_control_unit;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = 20'h00000;
  logic [3:0]  ALUFlags = 4'b0000;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0]  Flags;
  logic [3:0]  State;
`ifdef MCU_ILLEGAL_TRAP_EN
  logic        Illegal;
`endif

  multicycle_control_unit #(.RESET_FLAGS(4'b0000), .STATE_W(4)) dut (
    .CLK(CLK), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .Flags(Flags),
`ifdef MCU_ILLEGAL_TRAP_EN
    .Illegal(Illegal),
`endif
    .State(State)
  );

  always #5 CLK = ~CLK;

  logic [15:0] dut_vec;
  assign dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};

  int checks = 0;
  int errors = 0;
  logic [3:0]  mflags = 4'b0000;
  logic [19:0] cap_seq;
  logic [4:0]  cap_pcw, cap_rw, cap_mw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- reference model (instruction level) ----
  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? ~base : base;
  endfunction

  // Visited states, nibble i = state in cycle i (cycle 0 = FETCH)
  function automatic logic [19:0] m_seq(input logic [19:0] ins);
    case (ins[15:14])
      2'b00:   return ins[13] ? 20'h08710 : 20'h08610;
      2'b01:   return ins[8] ? 20'h43210 : 20'h05210;
      2'b10:   return 20'h00910;
      default: return 20'h00010;
    endcase
  endfunction

  function automatic int m_len(input logic [19:0] ins);
    case (ins[15:14])
      2'b00:   return 4;
      2'b01:   return ins[8] ? 5 : 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] m_aluctl(input logic [3:0] cmd);
    if (cmd == 4'b0010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [15:0] m_out(input logic [3:0] st, input logic ok, input logic [19:0] ins);
    logic pcw, adr, mw, irw, rw, asa;
    logic [1:0] rs, asb, alc, op;
    logic rdpc;
    op = ins[15:14];
    rdpc = (ins[3:0] == 4'hF);
    pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; asa = 1'b0;
    rs = 2'b00; asb = 2'b00; alc = 2'b00;
    case (st)
      4'd0: begin pcw = 1'b1; irw = 1'b1; asa = 1'b1; asb = 2'b10; rs = 2'b10; end
      4'd1: begin asa = 1'b1; asb = 2'b10; rs = 2'b10; end
      4'd2: asb = 2'b01;
      4'd3: adr = 1'b1;
      4'd4: begin rs = 2'b01; rw = ok; pcw = ok & rdpc; end
      4'd5: begin adr = 1'b1; mw = ok; end
      4'd6: alc = m_aluctl(ins[12:9]);
      4'd7: begin asb = 2'b01; alc = m_aluctl(ins[12:9]); end
      4'd8: begin rw = ok; pcw = ok & rdpc; end
      4'd9: begin asb = 2'b01; rs = 2'b10; pcw = ok; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rw, rs, asa, asb, alc, op, op == 2'b01, op == 2'b10};
  endfunction

  // Called just after a falling edge with the DUT in FETCH; leaves it there.
  task automatic run_instr(input logic [19:0] ins, input logic [3:0] af);
    logic [19:0] seq;
    logic [3:0] st;
    int len;
    logic ok;
    seq = m_seq(ins);
    len = m_len(ins);
    ok = m_cond(ins[19:16], mflags);
    cap_seq = 20'h0; cap_pcw = 5'b0; cap_rw = 5'b0; cap_mw = 5'b0;
    Instr = ins;
    ALUFlags = af;
    #1;
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        @(negedge CLK); #1;
      end
      st = seq[4*i +: 4];
      cap_seq[4*i +: 4] = State;
      cap_pcw[i] = PCWrite;
      cap_rw[i] = RegWrite;
      cap_mw[i] = MemWrite;
      chk("state", {28'h0, State}, {28'h0, st});
      chk("outputs", {16'h0, dut_vec}, {16'h0, m_out(st, ok, ins)});
    end
    if (ins[15:14] == 2'b00 && ins[8] && ok) begin
      mflags[3:2] = af[3:2];
      if (ins[12:9] == 4'b0100 || ins[12:9] == 4'b0010) mflags[1:0] = af[1:0];
    end
    @(negedge CLK); #1;
    chk("end_state", {28'h0, State}, 32'h0);
    chk("flags", {28'h0, Flags}, {28'h0, mflags});
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    #1;
    chk("rst_enables", {28'h0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'h0);
    for (int i = 0; i < cyc; i++) begin
      @(negedge CLK); #1;
      chk("rst_enables", {28'h0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'h0);
      chk("rst_state", {28'h0, State}, 32'h0);
      chk("rst_flags", {28'h0, Flags}, 32'h0);
    end
    reset = 1'b0;
    mflags = 4'b0000;
    #1;
  endtask

  typedef struct {
    logic [19:0] instr;
    logic [3:0]  af;
    logic [19:0] seq;
    logic [4:0]  pcw;
    logic [4:0]  rw;
    logic [4:0]  mw;
    logic [3:0]  flags;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [19:0] i, input logic [3:0] a, input logic [19:0] s,
                     input logic [4:0] p, input logic [4:0] r, input logic [4:0] m,
                     input logic [3:0] f);
    vec_t v;
    v.instr = i; v.af = a; v.seq = s; v.pcw = p; v.rw = r; v.mw = m; v.flags = f;
    tbl.push_back(v);
  endtask

  initial begin
    logic [19:0] ins;
    logic [5:0] funct;
    logic [3:0] rd, cond;
    logic [1:0] op;
    int cls;

    // instr, ALUFlags, states (cycle0 in LSB nibble), PCWrite/RegWrite/MemWrite per cycle, Flags after
    add(20'hE2821, 4'b0000, 20'h08710, 5'b00001, 5'b01000, 5'b00000, 4'b0000); // ADD R1,R2,#5
    add(20'hE0510, 4'b0100, 20'h08610, 5'b00001, 5'b01000, 5'b00000, 4'b0100); // SUBS, Z set
    add(20'h0A000, 4'b0000, 20'h00910, 5'b00101, 5'b00000, 5'b00000, 4'b0100); // BEQ taken
    add(20'hE0510, 4'b0000, 20'h08610, 5'b00001, 5'b01000, 5'b00000, 4'b0000); // SUBS clears
    add(20'h0A000, 4'b0000, 20'h00910, 5'b00001, 5'b00000, 5'b00000, 4'b0000); // BEQ not taken
    add(20'hE5912, 4'b0000, 20'h43210, 5'b00001, 5'b10000, 5'b00000, 4'b0000); // LDR
    add(20'hE5812, 4'b0000, 20'h05210, 5'b00001, 5'b00000, 5'b01000, 4'b0000); // STR
    add(20'hE282F, 4'b0000, 20'h08710, 5'b01001, 5'b01000, 5'b00000, 4'b0000); // ADD R15
    add(20'h02821, 4'b0000, 20'h08710, 5'b00001, 5'b00000, 5'b00000, 4'b0000); // ADDEQ fails
    add(20'hE591F, 4'b0000, 20'h43210, 5'b10001, 5'b10000, 5'b00000, 4'b0000); // LDR R15
    add(20'hE0110, 4'b1111, 20'h08610, 5'b00001, 5'b01000, 5'b00000, 4'b1100); // ANDS: NZ only
    add(20'hE0910, 4'b0011, 20'h08610, 5'b00001, 5'b01000, 5'b00000, 4'b0011); // ADDS: all
    add(20'h82821, 4'b0000, 20'h08710, 5'b00001, 5'b01000, 5'b00000, 4'b0011); // HI passes
    add(20'hB2821, 4'b0000, 20'h08710, 5'b00001, 5'b01000, 5'b00000, 4'b0011); // LT passes
    add(20'hC2821, 4'b0000, 20'h08710, 5'b00001, 5'b00000, 5'b00000, 4'b0011); // GT fails
    add(20'hF2821, 4'b0000, 20'h08710, 5'b00001, 5'b00000, 5'b00000, 4'b0011); // cond 1111
    add(20'h00110, 4'b1111, 20'h08610, 5'b00001, 5'b00000, 5'b00000, 4'b0011); // ANDSEQ fails
`ifndef MCU_ILLEGAL_TRAP_EN
    add(20'hEC000, 4'b0000, 20'h00010, 5'b00001, 5'b00000, 5'b00000, 4'b0011); // op=11 NOP
`endif

    @(negedge CLK); #1;
    do_reset(2);

    foreach (tbl[k]) begin
      run_instr(tbl[k].instr, tbl[k].af);
      chk("tbl_states", {12'h0, cap_seq}, {12'h0, tbl[k].seq});
      chk("tbl_pcwrite", {27'h0, cap_pcw}, {27'h0, tbl[k].pcw});
      chk("tbl_regwrite", {27'h0, cap_rw}, {27'h0, tbl[k].rw});
      chk("tbl_memwrite", {27'h0, cap_mw}, {27'h0, tbl[k].mw});
      chk("tbl_flags", {28'h0, Flags}, {28'h0, tbl[k].flags});
    end

    // Reset during MEMRD of an LDR after flags have been made non-zero
    run_instr(20'hE0510, 4'b1111);
    chk("pre_reset_flags", {28'h0, Flags}, 32'hF);
    Instr = 20'hE5912;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge CLK); #1;
      end
      chk("ldr_abort_state", {28'h0, State}, i);
      chk("ldr_abort_rw", {31'h0, RegWrite}, 32'h0);
    end
    do_reset(1);
    chk("abort_rw_fetch", {31'h0, RegWrite}, 32'h0);
    run_instr(20'hE5912, 4'b0000);

`ifdef MCU_ILLEGAL_TRAP_EN
    Instr = 20'hEC000;
    #1;
    chk("trap_fetch", {28'h0, State}, 32'h0);
    @(negedge CLK); #1;
    chk("trap_decode", {28'h0, State}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      chk("trap_halt", {28'h0, State}, 32'hA);
      chk("trap_illegal", {31'h0, Illegal}, 32'h1);
      chk("trap_enables", {28'h0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'h0);
    end
    do_reset(1);
    chk("trap_cleared", {31'h0, Illegal}, 32'h0);
`endif

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      cls = $urandom_range(0, 4);
      cond = 4'($urandom_range(0, 15));
      funct = 6'($urandom_range(0, 63));
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      case (cls)
        0, 1: begin
          op = 2'b00;
          funct[5] = (cls == 1);
`ifdef MCU_ILLEGAL_TRAP_EN
          if (!(funct[4:1] == 4'b0100 || funct[4:1] == 4'b0010 ||
                funct[4:1] == 4'b0000 || funct[4:1] == 4'b1100)) funct[4:1] = 4'b0100;
`endif
        end
        2: op = 2'b01;
        3: op = 2'b10;
        default: begin
`ifdef MCU_ILLEGAL_TRAP_EN
          op = 2'b10;
`else
          op = 2'b11;
`endif
        end
      endcase
      ins = {cond, op, funct, 4'($urandom_range(0, 15)), rd};
      run_instr(ins, 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
